// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles a 32-bit instruction from four byte
// reads, presents it to IF/ID and handles EX branch redirects.
module if_fetch #(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      INST_W   = 32,
    parameter int unsigned      STALL_W  = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall_state,
    input  logic                ex_b_flag_i,
    input  logic [ADDR_W-1:0]   ex_b_target_i,
    input  logic                mem_busy_i,
    input  logic [7:0]          mem_data_i,
    output logic                mem_rd_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                stallreq_if_o,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [INST_W-1:0]   if_inst
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] BYTES = 3'd4;

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [CNT_W-1:0]  issue_cnt, issue_n;
    logic [CNT_W-1:0]  recv_cnt, recv_n;
    logic              inflight, inflight_n;
    logic [INST_W-1:0] inst_buf, inst_buf_n;

    // Only the PC-stage stall bit matters here.
    logic unused_stall;
    assign unused_stall = ^stall_state[STALL_W-1:1];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            inflight  <= 1'b0;
            inst_buf  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            issue_cnt <= issue_n;
            recv_cnt  <= recv_n;
            inflight  <= inflight_n;
            inst_buf  <= inst_buf_n;
        end
    end

    // Next-state and output logic; a branch overrides everything else.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        issue_n       = issue_cnt;
        recv_n        = recv_cnt;
        inflight_n    = 1'b0;
        inst_buf_n    = inst_buf;
        mem_rd_o      = 1'b0;
        mem_addr_o    = pc + ADDR_W'(issue_cnt);
        stallreq_if_o = 1'b0;
        if_pc         = pc;
        if_inst       = '0;

        case (state)
            FETCH: begin
                stallreq_if_o = 1'b1;
                mem_rd_o      = (issue_cnt < BYTES) && !mem_busy_i && !ex_b_flag_i;
                if (mem_rd_o) begin
                    issue_n = issue_cnt + 3'd1;
                end
                inflight_n = mem_rd_o;
                // Byte issued last cycle lands little-endian at recv_cnt.
                if (inflight) begin
                    inst_buf_n[{recv_cnt[1:0], 3'b000} +: 8] = mem_data_i;
                    recv_n = recv_cnt + 3'd1;
                    if (recv_cnt == 3'd3) begin
                        state_n = READY;
                    end
                end
            end
            READY: begin
                if_inst = inst_buf;
                if (!stall_state[0]) begin
                    pc_n    = pc + ADDR_W'(4);
                    issue_n = '0;
                    recv_n  = '0;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        // Redirect aborts any in-flight fetch; a late byte is dropped.
        if (ex_b_flag_i) begin
            pc_n       = ex_b_target_i;
            issue_n    = '0;
            recv_n     = '0;
            inflight_n = 1'b0;
            state_n    = FETCH;
        end

        // Quiet outputs while reset is held.
        if (rst) begin
            mem_rd_o      = 1'b0;
            stallreq_if_o = 1'b0;
            if_inst       = '0;
            if_pc         = RESET_PC;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch with a one-cycle-latency byte memory model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_state;
    logic        ex_b_flag_i;
    logic [31:0] ex_b_target_i;
    logic        mem_busy_i;
    logic [7:0]  mem_data_i;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        stallreq_if_o;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int n_chk  = 0;
    int n_pass = 0;

    if_fetch #(
        .ADDR_W(32), .INST_W(32), .STALL_W(6), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .stall_state(stall_state),
        .ex_b_flag_i(ex_b_flag_i), .ex_b_target_i(ex_b_target_i),
        .mem_busy_i(mem_busy_i), .mem_data_i(mem_data_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .stallreq_if_o(stallreq_if_o), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    // Memory image; unlisted addresses read as zero.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 8'h13;
            32'h0000_0001: return 8'h05;
            32'h0000_0002: return 8'h10;
            32'h0000_0003: return 8'h00;
            32'h0000_0004: return 8'h11;
            32'h0000_0005: return 8'h22;
            32'h0000_0006: return 8'h33;
            32'h0000_0007: return 8'h44;
            32'h0000_0040: return 8'hEF;
            32'h0000_0041: return 8'h00;
            32'h0000_0042: return 8'h40;
            32'h0000_0043: return 8'h00;
            32'h0000_0100: return 8'h93;
            32'h0000_0101: return 8'h80;
            32'h0000_0102: return 8'h00;
            32'h0000_0103: return 8'h20;
            32'hFFFF_FFFE: return 8'hAA;
            32'hFFFF_FFFF: return 8'hBB;
            default:       return 8'h00;
        endcase
    endfunction

    // Byte returned one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        mem_data_i <= mem_rd_o ? mem_byte(mem_addr_o) : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 2 units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        settle();
        check("rst_rd", 32'(mem_rd_o), 32'd0);
        check("rst_stallreq", 32'(stallreq_if_o), 32'd0);
        check("rst_inst", if_inst, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        rst = 1'b0;
    endtask

    // Uninterrupted fetch from cycle 0; ends in the READY cycle, not stepped past it.
    task automatic run_fetch(input string tag, input logic [31:0] base, input logic [31:0] exp_inst);
        for (int i = 0; i < 4; i++) begin
            settle();
            check({tag, "_rd"}, 32'(mem_rd_o), 32'd1);
            check({tag, "_addr"}, mem_addr_o, base + 32'(i));
            check({tag, "_stallreq"}, 32'(stallreq_if_o), 32'd1);
            step();
        end
        settle();
        check({tag, "_c4_rd"}, 32'(mem_rd_o), 32'd0);
        check({tag, "_c4_inst"}, if_inst, 32'd0);
        step();
        settle();
        check({tag, "_rdy_stallreq"}, 32'(stallreq_if_o), 32'd0);
        check({tag, "_rdy_rd"}, 32'(mem_rd_o), 32'd0);
        check({tag, "_rdy_pc"}, if_pc, base);
        check({tag, "_rdy_inst"}, if_inst, exp_inst);
    endtask

    initial begin
        rst = 1'b1; stall_state = '0; ex_b_flag_i = 1'b0;
        ex_b_target_i = '0; mem_busy_i = 1'b0;

        // Basic fetch at reset PC, then next issue at 4.
        do_reset();
        run_fetch("f0", 32'h0, 32'h0010_0513);
        step(); settle();
        check("next_rd", 32'(mem_rd_o), 32'd1);
        check("next_addr", mem_addr_o, 32'h4);

        // Memory busy on cycle 1 delays issue but keeps byte 0.
        do_reset();
        settle(); check("busy_c0_addr", mem_addr_o, 32'h0);
        step();
        mem_busy_i = 1'b1; settle();
        check("busy_c1_rd", 32'(mem_rd_o), 32'd0);
        step();
        mem_busy_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            settle();
            check("busy_addr", mem_addr_o, 32'(i));
            step();
        end
        settle(); check("busy_c5_stallreq", 32'(stallreq_if_o), 32'd1);
        step(); settle();
        check("busy_rdy_inst", if_inst, 32'h0010_0513);
        check("busy_rdy_stallreq", 32'(stallreq_if_o), 32'd0);

        // Hold READY for three cycles under PC stall.
        for (int i = 0; i < 3; i++) begin
            stall_state = 6'b000001; settle();
            check("hold_pc", if_pc, 32'h0);
            check("hold_inst", if_inst, 32'h0010_0513);
            check("hold_rd", 32'(mem_rd_o), 32'd0);
            step();
        end
        stall_state = 6'b000000; settle();
        check("hold_release_stallreq", 32'(stallreq_if_o), 32'd0);
        step();
        run_fetch("f4", 32'h4, 32'h4433_2211);

        // Branch mid-fetch aborts and redirects to 0x100.
        do_reset();
        step(); step();
        ex_b_flag_i = 1'b1; ex_b_target_i = 32'h100; settle();
        check("br_rd", 32'(mem_rd_o), 32'd0);
        step();
        ex_b_flag_i = 1'b0;
        run_fetch("f100", 32'h100, 32'h2000_8093);

        // Branch coincident with READY advance wins over pc+4.
        ex_b_flag_i = 1'b1; ex_b_target_i = 32'h40;
        step();
        ex_b_flag_i = 1'b0;
        settle(); check("brrdy_pc", if_pc, 32'h40);
        run_fetch("f40", 32'h40, 32'h0040_00EF);

        // Address wrap near the top of memory.
        ex_b_flag_i = 1'b1; ex_b_target_i = 32'hFFFF_FFFE;
        step();
        ex_b_flag_i = 1'b0;
        run_fetch("fwrap", 32'hFFFF_FFFE, 32'h0513_BBAA);
        step(); settle();
        check("wrap_next_addr", mem_addr_o, 32'h2);

        // Reset mid-fetch discards partial data.
        step(); step();
        do_reset();
        run_fetch("frst", 32'h0, 32'h0010_0513);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
